// File: rtl/cic_comb_mc_if.sv
// Sample bus into and out of the multi-channel CIC comb: tagged input samples, tagged filtered outputs.
// The source side uses master; the comb itself uses slave.
interface cic_comb_mc_if #(
  parameter int DATA_WIDTH = 22,
  parameter int OUT_WIDTH  = 16,
  parameter int NUM_CH     = 1,
  parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
  logic                  ND;
  logic [CH_W-1:0]       Xch;
  logic [DATA_WIDTH-1:0] Xin;
  logic                  Yvld;
  logic [CH_W-1:0]       Ych;
  logic [OUT_WIDTH-1:0]  Yout;

  modport master (
    output ND, Xch, Xin,
    input  Yvld, Ych, Yout
  );

  modport slave (
    input  ND, Xch, Xin,
    output Yvld, Ych, Yout
  );
endinterface

// File: rtl/cic_comb_mc.sv
// N-stage TDM comb y=x[n]-x[n-M] with per-channel delay state, round-half-up and saturating output.
// Latency N+1 clocks from the accepting edge; one sample per clock, no backpressure (ND is a plain strobe).
module cic_comb_mc #(
  parameter int DATA_WIDTH = 22,
  parameter int N          = 3,
  parameter int M          = 1,
  parameter int NUM_CH     = 1,
  parameter int OUT_WIDTH  = 16,
  parameter int OUT_SHIFT  = 6,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input logic           clk,
  input logic           rst,
  input logic           clr,
  cic_comb_mc_if.slave  io
);

  localparam int DW   = DATA_WIDTH;
  localparam int OW   = OUT_WIDTH;
  // Delay memory is sized to the full tag range so any tag indexes it cleanly.
  localparam int CH_N = 1 << CH_W;

  localparam logic signed [DW:0] RND  = ((DW+1)'(1) << OUT_SHIFT) >> 1;
  localparam logic signed [DW:0] OMAX = {{(DW-OW+2){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [DW:0] OMIN = {{(DW-OW+2){1'b1}}, {(OW-1){1'b0}}};

  // Index 0 is the input capture register, index k the output of comb stage k.
  logic [DW-1:0]   p_dat [0:N];
  logic [CH_W-1:0] p_ch  [0:N];
  logic [N:0]      p_vld;
  logic [DW-1:0]   dl    [1:N][0:CH_N-1][0:M-1];

  logic                 acc;
  logic signed [DW:0]   s_ext;
  logic signed [DW:0]   r;
  logic [OW-1:0]        sat;
  logic                 yvld;
  logic [CH_W-1:0]      ych;
  logic [OW-1:0]        yout;

  assign acc = io.ND && ({1'b0, io.Xch} < (CH_W+1)'(NUM_CH));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_vld <= '0;
      for (int k = 0; k <= N; k++) begin
        p_dat[k] <= '0;
        p_ch[k]  <= '0;
      end
      for (int k = 1; k <= N; k++)
        for (int c = 0; c < CH_N; c++)
          for (int m = 0; m < M; m++)
            dl[k][c][m] <= '0;
    end else if (clr) begin
      p_vld <= '0;
      for (int k = 1; k <= N; k++)
        for (int c = 0; c < CH_N; c++)
          for (int m = 0; m < M; m++)
            dl[k][c][m] <= '0;
    end else begin
      p_vld[0] <= acc;
      if (acc) begin
        p_dat[0] <= io.Xin;
        p_ch[0]  <= io.Xch;
      end
      // Each stage reads its old delay tap and pushes the new input in the same edge,
      // so back-to-back samples of one channel see the correct history.
      for (int k = 1; k <= N; k++) begin
        p_vld[k] <= p_vld[k-1];
        if (p_vld[k-1]) begin
          p_dat[k] <= p_dat[k-1] - dl[k][p_ch[k-1]][M-1];
          p_ch[k]  <= p_ch[k-1];
          for (int m = M - 1; m > 0; m--)
            dl[k][p_ch[k-1]][m] <= dl[k][p_ch[k-1]][m-1];
          dl[k][p_ch[k-1]][0] <= p_dat[k-1];
        end
      end
    end
  end

  // One extra bit keeps the rounding add from overflowing before the shift.
  always_comb begin
    s_ext = {p_dat[N][DW-1], p_dat[N]};
    r     = (s_ext + RND) >>> OUT_SHIFT;
    if (r > OMAX)
      sat = OMAX[OW-1:0];
    else if (r < OMIN)
      sat = OMIN[OW-1:0];
    else
      sat = r[OW-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      yvld <= 1'b0;
      ych  <= '0;
      yout <= '0;
    end else begin
      yvld <= p_vld[N] && !clr;
      if (p_vld[N] && !clr) begin
        yout <= sat;
        ych  <= p_ch[N];
      end
    end
  end

  assign io.Yvld = yvld;
  assign io.Ych  = ych;
  assign io.Yout = yout;

endmodule

// File: tb/tb_cic_comb_mc.sv
// Directed bench for cic_comb_mc: three configurations exercised one after another on a shared clock.
module tb_cic_comb_mc;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clr = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   t_acc;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cic_comb_mc_if #(.DATA_WIDTH(22), .OUT_WIDTH(22), .NUM_CH(3)) ifa ();
  cic_comb_mc_if #(.DATA_WIDTH(22), .OUT_WIDTH(22), .NUM_CH(1)) ifb ();
  cic_comb_mc_if #(.DATA_WIDTH(22), .OUT_WIDTH(8),  .NUM_CH(1)) ifc ();

  cic_comb_mc #(.DATA_WIDTH(22), .N(3), .M(1), .NUM_CH(3), .OUT_WIDTH(22), .OUT_SHIFT(0))
    u_a (.clk(clk), .rst(rst), .clr(clr), .io(ifa));
  cic_comb_mc #(.DATA_WIDTH(22), .N(1), .M(2), .NUM_CH(1), .OUT_WIDTH(22), .OUT_SHIFT(0))
    u_b (.clk(clk), .rst(rst), .clr(clr), .io(ifb));
  cic_comb_mc #(.DATA_WIDTH(22), .N(1), .M(1), .NUM_CH(1), .OUT_WIDTH(8), .OUT_SHIFT(2))
    u_c (.clk(clk), .rst(rst), .clr(clr), .io(ifc));

  int qa_v[$];
  int qa_c[$];
  int qa_t[$];
  int qb_v[$];
  int qc_v[$];

  always @(negedge clk) begin
    if (ifa.Yvld) begin
      qa_v.push_back(int'($signed(ifa.Yout)));
      qa_c.push_back(int'(ifa.Ych));
      qa_t.push_back(cyc);
    end
    if (ifb.Yvld) qb_v.push_back(int'($signed(ifb.Yout)));
    if (ifc.Yvld) qc_v.push_back(int'($signed(ifc.Yout)));
  end

  int exp_imp  [6] = '{1, -3, 3, -1, 0, 0};
  int exp_step [6] = '{5, -10, 5, 0, 0, 0};
  int gap      [6] = '{0, 1, 2, 3, 1, 0};
  int exp_il   [8] = '{1, 7, -3, -14, 3, 7, -1, 0};
  int exp_b    [3] = '{-2097152, 0, -1};
  int in_c     [6] = '{6, 1006, 6, 4, 1, 3};
  int exp_c    [6] = '{2, 127, -128, 0, -1, 1};

  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus to the selected instance; the others see ND=0.
  task automatic send(input int sel, input logic nd, input int ch, input int x);
    ifa.ND  = (sel == 0) && nd;
    ifb.ND  = (sel == 1) && nd;
    ifc.ND  = (sel == 2) && nd;
    ifa.Xch = ch[1:0];
    ifb.Xch = ch[0];
    ifc.Xch = ch[0];
    ifa.Xin = x[21:0];
    ifb.Xin = x[21:0];
    ifc.Xin = x[21:0];
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) send(0, 1'b0, 0, 0);
  endtask

  function automatic void clr_q();
    qa_v.delete();
    qa_c.delete();
    qa_t.delete();
    qb_v.delete();
    qc_v.delete();
  endfunction

  task automatic impulse_a(input string tag);
    clr_q();
    send(0, 1'b1, 0, 1);
    repeat (3) send(0, 1'b1, 0, 0);
    idle(8);
    chk({tag, "_n"}, qa_v.size(), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("%s%0d", tag, i), qa_v[i], exp_imp[i]);
  endtask

  initial begin
    ifa.ND = 1'b0; ifb.ND = 1'b0; ifc.ND = 1'b0;
    ifa.Xch = '0;  ifb.Xch = '0;  ifc.Xch = '0;
    ifa.Xin = '0;  ifb.Xin = '0;  ifc.Xin = '0;
    repeat (3) @(negedge clk);
    chk("rst_yvld", ifa.Yvld, 0);
    chk("rst_ych",  ifa.Ych, 0);
    chk("rst_yout", ifa.Yout, 0);
    chk("rst_youtc", ifc.Yout, 0);
    rst = 1'b1;
    @(negedge clk);

    // impulse on back-to-back samples, plus latency
    clr_q();
    send(0, 1'b1, 0, 1);
    t_acc = cyc;
    repeat (5) send(0, 1'b1, 0, 0);
    idle(8);
    chk("imp_n", qa_v.size(), 6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("imp%0d", i), qa_v[i], exp_imp[i]);
    chk("imp_lat", qa_t[0] - t_acc, 4);

    // step with ND gaps
    clr_q();
    for (int i = 0; i < 6; i++) begin
      send(0, 1'b1, 0, 5);
      idle(gap[i]);
    end
    idle(8);
    chk("step_n", qa_v.size(), 6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("step%0d", i), qa_v[i], exp_step[i]);

    clr = 1'b1;
    send(0, 1'b0, 0, 0);
    clr = 1'b0;

    // two interleaved channels, then an out-of-range tag
    clr_q();
    for (int i = 0; i < 4; i++) begin
      send(0, 1'b1, 0, (i == 0) ? 1 : 0);
      send(0, 1'b1, 1, 7);
    end
    send(0, 1'b1, 3, 100);
    idle(8);
    chk("il_n", qa_v.size(), 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("il_v%0d", i), qa_v[i], exp_il[i]);
      chk($sformatf("il_c%0d", i), qa_c[i], i % 2);
    end

    // clr mid-stream with ND on the same edge
    clr_q();
    send(0, 1'b1, 0, 9);
    send(0, 1'b1, 0, 9);
    clr = 1'b1;
    send(0, 1'b1, 0, 50);
    clr = 1'b0;
    idle(8);
    chk("clr_n", qa_v.size(), 0);
    chk("clr_ych_hold", ifa.Ych, 1);
    impulse_a("clr_imp");

    // reset mid-stream
    clr_q();
    send(0, 1'b1, 0, 3);
    repeat (4) send(0, 1'b1, 0, 0);
    ifa.ND = 1'b0;
    chk("pre_rst", $signed(ifa.Yout), 3);
    #2 rst = 1'b0;
    #1;
    chk("rst2_yout", ifa.Yout, 0);
    chk("rst2_yvld", ifa.Yvld, 0);
    @(negedge clk);
    clr_q();
    rst = 1'b1;
    idle(8);
    chk("rst2_n", qa_v.size(), 0);
    impulse_a("rst_imp");

    // M=2 wrap
    clr_q();
    send(1, 1'b1, 0, -2097152);
    send(1, 1'b1, 0, 0);
    send(1, 1'b1, 0, 2097151);
    idle(5);
    chk("wrap_n", qb_v.size(), 3);
    for (int i = 0; i < 3; i++)
      chk($sformatf("wrap%0d", i), qb_v[i], exp_b[i]);

    // rounding and saturation
    clr_q();
    for (int i = 0; i < 6; i++)
      send(2, 1'b1, 0, in_c[i]);
    idle(5);
    chk("sat_n", qc_v.size(), 6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("sat%0d", i), qc_v[i], exp_c[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cic_comb_mc.md
Name: cic_comb_mc

Overview:
Parametrised multi-channel comb section for the CIC decimator in the pulse-compression receive chain. It is the successor to the fixed-depth single-channel comb. It implements N cascaded comb stages, each computing y[n] = x[n] - x[n-M], on time-division-multiplexed channels. Each stage is pipelined and holds independent per-channel delay state. The output is rounded and saturated. It sits after the decimating integrator/downsampler and feeds the matched filter.

Parameters:
DATA_WIDTH, 22, internal and input word width (two's complement)
N, 3, number of comb stages (1..10)
M, 1, differential delay per stage (1 or 2)
NUM_CH, 1, number of interleaved channels (1..16)
OUT_WIDTH, 16, output word width (<= DATA_WIDTH)
OUT_SHIFT, 6, arithmetic right shift applied before output (0..DATA_WIDTH-1)
CH_W, derived = max(1, clog2(NUM_CH)), channel tag width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low
clr  in  1  synchronous clear of all delay state and pipeline valids
ND  in  1  input sample valid
Xch  in  CH_W  channel index of Xin
Xin  in  DATA_WIDTH  signed input sample
Yvld  out  1  output valid, one cycle per accepted sample
Ych  out  CH_W  channel index of Yout
Yout  out  OUT_WIDTH  signed filtered, rounded, saturated output

Behaviour:
- Reset (rst=0, asynchronous): all delay memories, pipeline data and valid registers clear to 0. Yvld=0, Ych=0, Yout=0. The block resumes on the first clk edge after rst releases.
- Accept: a sample is accepted on a clk edge with ND=1, clr=0, and Xch<NUM_CH. If Xch>=NUM_CH, the sample is dropped: no state update and no output.
- Stage k (1..N): per-channel delay line dl_k[ch][0..M-1].
  - When the stage's valid input is for channel ch, the stage output is in_k - dl_k[ch][M-1].
  - In the same edge, dl_k[ch] shifts and dl_k[ch][0] <= in_k.
  - Read-before-write within the edge. Other channels' state is untouched.
- Pipeline: one register per stage carries data, channel tag and valid, followed by one output register.
  - Fixed latency N+1 clocks: a sample accepted at edge t produces Yvld=1 after edge t+N+1.
  - Samples keep their order. Throughput is one sample per clock.
  - Back-to-back samples of the same channel are legal and hazard-free.
- ND gaps: bubbles propagate. Delay state is held; only valid samples advance the state.
- Arithmetic: all stage subtractions are DATA_WIDTH-bit, modulo 2^DATA_WIDTH, with intentional wrap and no saturation, as CIC operation requires.
- Output stage:
  - If OUT_SHIFT>0: r = (s + 2^(OUT_SHIFT-1)) >>> OUT_SHIFT, computed at DATA_WIDTH+1 bits, so rounding is round-half-up.
  - If OUT_SHIFT=0: r = s.
  - Saturate r to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - Yout holds its last value when Yvld=0.
- clr=1: on that edge, all delay memories and pipeline valids go to 0, and Yvld goes to 0 next cycle. Any ND on the same edge is ignored (clr has priority). Samples in flight are discarded. Yout/Ych hold.
- Reset mid-operation: in-flight samples are lost and no spurious Yvld is produced after release.
- Startup: delay memories read as 0. The first M·N outputs per channel are the transient of the filter acting on a zero history.

Test Plan:
- N=3, M=1, NUM_CH=1, OUT_SHIFT=0, OUT_WIDTH=22: impulse Xin=1 then 0s on consecutive ND -> Yout sequence 1,-3,3,-1,0,0; first Yvld exactly 4 clocks after the accepting edge.
- Same config, step Xin=5 held -> Yout 5,-10,5,0,0…; then insert ND-low gaps of 1–3 cycles -> identical value sequence, Yvld only for accepted samples.
- N=1, M=2, DATA_WIDTH=22: Xin = -2097152, 0, 2097151 -> Yout -2097152, 0, -1 (wrap of 2^22-1 to -1).
- N=3, M=1, NUM_CH=2: interleave ch0 impulse (1,0,0,0) with ch1 constant 7 -> ch0 outputs 1,-3,3,-1 and ch1 outputs 7,-14,7,0; Ych tags alternate 0,1. Xch=3 with NUM_CH=2 -> dropped, no Yvld.
- N=1, M=1, OUT_SHIFT=2, OUT_WIDTH=8, from zero history: Xin=6 -> Yout 2; then Xin=1006 -> 127 (sat); then Xin=6 -> -128 (sat).
- Assert clr mid-stream with ND=1 on the same edge -> that sample ignored, no Yvld for in-flight samples, next impulse reproduces 1,-3,3,-1. Repeat with rst=0 pulse -> outputs 0 immediately, same recovery.
